stream_bit_reversal: RTL
========================

Name: stream_bit_reversal

Overview:
Streaming, parametrised bit-reversal permutation buffer for the NTT datapath. It accepts a frame of N = 2^LOG_N coefficients in natural order over a valid/ready stream. It emits the same frame in bit-reversed index order, or in natural order when bypass is selected. Ping-pong double buffering lets one frame fill while the previous frame drains, which sustains one coefficient per cycle between the input loader and the butterfly stages.

Parameters:
WIDTH, 8, coefficient bit width
LOG_N, 3, log2 of frame length; N = 2^LOG_N coefficients per frame (LOG_N >= 1)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  reset, synchronous, active-high
in_valid  input  1  in_data is valid
in_ready  output  1  block can accept in_data this cycle
in_data  input  WIDTH  coefficient, natural index order
in_bypass  input  1  mode for the current input frame; sampled only with the first accepted word of a frame (1 = natural-order output)
out_valid  output  1  out_data is valid
out_ready  input  1  downstream accepts out_data
out_data  output  WIDTH  coefficient, permuted order
out_last  output  1  high with the final (N-th) word of an output frame
out_index  output  LOG_N  natural input index of the word on out_data

Behaviour:
- Storage: two banks of N x WIDTH registers (bank0, bank1). Per-bank full flag and per-bank latched bypass bit.
- Write side: wr_bank, wr_cnt[LOG_N-1:0].
  - in_ready = !full[wr_bank].
  - Accept = in_valid && in_ready. On accept, bank[wr_bank][wr_cnt] <= in_data.
  - If wr_cnt == 0, latch in_bypass into byp[wr_bank].
  - If wr_cnt == N-1: set full[wr_bank], toggle wr_bank, wr_cnt wraps to 0. Otherwise wr_cnt++.
- Read side: rd_bank, rd_cnt[LOG_N-1:0].
  - out_valid = full[rd_bank].
  - idx = byp[rd_bank] ? rd_cnt : bitrev(rd_cnt), where bitrev maps bit k to bit LOG_N-1-k.
  - out_data = bank[rd_bank][idx]; out_index = idx; out_last = out_valid && (rd_cnt == N-1).
  - Outputs are driven from registers through a mux only; in_* has no combinational path to out_*.
  - Fire = out_valid && out_ready. On fire: if rd_cnt == N-1, clear full[rd_bank], toggle rd_bank, rd_cnt wraps to 0. Otherwise rd_cnt++.
- out_data, out_index and out_last hold stable while out_valid && !out_ready.
- Latency: if the last word of a frame is accepted at edge t, out_valid is high after edge t, carrying the word with idx 0 (output index 0 is input index 0).
- Throughput: 1 word/cycle sustained with continuous in_valid and out_ready. in_ready never drops unless both banks are full.
- Simultaneous events:
  - Write completing on one bank and read completing on the other in the same cycle: both flag updates apply.
  - The write side never targets a full bank, and the read side never reads a non-full bank.
  - A bank freed by a read completion becomes writable in the next cycle (no same-cycle pass-through).
- Full: with both banks full, in_ready = 0 and in_data is ignored.
- Empty: out_valid = 0; out_data, out_index and out_last are don't-care but out_last = 0.
- Reset (at any time, including mid-frame):
  - full[1:0] = 0, wr_bank = rd_bank = 0, wr_cnt = rd_cnt = 0, byp = 0.
  - Partial or pending frames are discarded.
  - Outputs after the reset edge: in_ready = 1, out_valid = 0, out_last = 0.
  - Bank contents are not reset.

Test Plan:
- Basic reversal, LOG_N=3: feed 10..17 (bypass = 0), out_ready = 1. Required output 10,14,12,16,11,15,13,17 with out_index 0,4,2,6,1,5,3,7. out_last is high only on 17. out_valid rises the cycle after the 8th accept.
- Streaming throughput: 4 back-to-back frames with in_valid = out_ready = 1 constantly. Required: in_ready stays 1; 32 outputs with no bubbles after the first frame's latency; each frame is correctly permuted.
- Backpressure: out_ready = 0, feed 20 words. Required: exactly 16 accepted, in_ready = 0 after the 16th. Then raise out_ready: frame 1 drains, in_ready returns 1 the cycle after frame 1's out_last fires, and the remaining 4 words are accepted.
- Bypass per frame: frame A (bypass = 1) 0..7, then frame B (bypass = 0) 0..7. Required output 0..7 followed by 0,4,2,6,1,5,3,7. Toggling in_bypass mid-frame has no effect.
- Reset mid-operation: assert rst after 5 words of frame 2 while frame 1 is draining (rd_cnt = 3). Required: after the edge, out_valid = 0 and in_ready = 1. A fresh frame 30..37 then outputs 30,34,32,36,31,35,33,37.
- Parameter sweep LOG_N=4, WIDTH=16: feed 0..15. Required output 0,8,4,12,2,10,6,14,1,9,5,13,3,11,7,15 with out_last on 15.

Source files
------------

// File: rtl/stream_bit_reversal.sv
// Ping-pong bit-reversal permutation buffer for the NTT datapath.
// One bank fills in natural order while the other drains in bit-reversed
// (or natural, when the frame was tagged bypass) order, sustaining one
// coefficient per cycle on both sides.
module stream_bit_reversal #(
    parameter int WIDTH = 8,
    parameter int LOG_N = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_bypass,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    output logic [LOG_N-1:0] out_index
);

    localparam int N = 1 << LOG_N;
    localparam logic [LOG_N-1:0] LAST_CNT = LOG_N'(N - 1);

    logic [WIDTH-1:0] bank0 [N];
    logic [WIDTH-1:0] bank1 [N];

    logic [1:0]       full;
    logic [1:0]       byp;
    logic             wr_bank;
    logic             rd_bank;
    logic [LOG_N-1:0] wr_cnt;
    logic [LOG_N-1:0] rd_cnt;
    logic [LOG_N-1:0] rev_cnt;
    logic [LOG_N-1:0] rd_idx;
    logic             accept;
    logic             fire;

    assign in_ready  = !full[wr_bank];
    assign accept    = in_valid && in_ready;
    assign out_valid = full[rd_bank];
    assign fire      = out_valid && out_ready;

    // Mirror the read counter so bit k lands on bit LOG_N-1-k.
    always_comb begin
        rev_cnt = '0;
        for (int k = 0; k < LOG_N; k++) begin
            rev_cnt[LOG_N-1-k] = rd_cnt[k];
        end
    end

    assign rd_idx    = byp[rd_bank] ? rd_cnt : rev_cnt;
    assign out_index = rd_idx;
    assign out_data  = rd_bank ? bank1[rd_idx] : bank0[rd_idx];
    assign out_last  = out_valid && (rd_cnt == LAST_CNT);

    // Coefficient storage; contents survive reset since the full flags gate them.
    always_ff @(posedge clk) begin
        if (accept) begin
            if (wr_bank) begin
                bank1[wr_cnt] <= in_data;
            end else begin
                bank0[wr_cnt] <= in_data;
            end
        end
    end

    // Write/read pointers, per-bank full flags and latched bypass mode.
    always_ff @(posedge clk) begin
        if (rst) begin
            full    <= '0;
            byp     <= '0;
            wr_bank <= 1'b0;
            rd_bank <= 1'b0;
            wr_cnt  <= '0;
            rd_cnt  <= '0;
        end else begin
            if (accept) begin
                if (wr_cnt == '0) begin
                    byp[wr_bank] <= in_bypass;
                end
                if (wr_cnt == LAST_CNT) begin
                    full[wr_bank] <= 1'b1;
                    wr_bank       <= !wr_bank;
                    wr_cnt        <= '0;
                end else begin
                    wr_cnt <= wr_cnt + 1'b1;
                end
            end
            if (fire) begin
                if (rd_cnt == LAST_CNT) begin
                    full[rd_bank] <= 1'b0;
                    rd_bank       <= !rd_bank;
                    rd_cnt        <= '0;
                end else begin
                    rd_cnt <= rd_cnt + 1'b1;
                end
            end
        end
    end

endmodule
